// File: rtl/elastic_reg_pipe_pkg.sv
// Shared defaults for the elastic register pipeline.
//   ERP_DEFAULT_WIDTH : default data bits per beat
//   ERP_DEFAULT_DEPTH : default number of register stages
package elastic_reg_pipe_pkg;

  localparam int ERP_DEFAULT_WIDTH = 8;
  localparam int ERP_DEFAULT_DEPTH = 3;

endpackage

// File: rtl/elastic_reg_stage.sv
// One stage of the elastic pipeline: a valid bit plus a data register.
// Ports:
//   Clk, Reset (async, active-high), Flush (sync clear)
//   up_valid / up_data : beat offered by the previous stage (or the input)
//   adv                : this stage may load from upstream this cycle
//   v_q / d_q          : registered valid / data of this stage
module elastic_reg_stage #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             adv,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);

  logic             v_d;
  logic [WIDTH-1:0] d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (Flush) begin
      v_d = 1'b0;
      d_d = RESET_VALUE;
    end else if (adv) begin
      v_d = up_valid;
      // Data only moves with a valid beat, so In_Data is never sampled when idle.
      if (up_valid) d_d = up_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v_q <= 1'b0;
      d_q <= RESET_VALUE;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/elastic_reg_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow control.
// Bubbles collapse under back-pressure; unstalled latency is DEPTH cycles.
// Ports:
//   Clk, Reset (async, active-high), Flush (sync clear of all stages)
//   In_Data / In_Valid / In_Ready    : upstream handshake
//   Out_Data / Out_Valid / Out_Ready : downstream handshake (registered outputs)
//   Occupancy                        : number of stages holding a beat
module elastic_reg_pipe
  import elastic_reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = ERP_DEFAULT_WIDTH,
  parameter int               DEPTH       = ERP_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [OCC_W-1:0] Occupancy
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic                        in_take;

  // A stage may load when the stage after it moves or it is empty; the chain
  // runs combinationally from the output back to the input.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = Out_Ready | ~v[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) adv[k] = adv[k+1] | ~v[k];
  end

  assign In_Ready = adv[0] & ~Flush & ~Reset;
  assign in_take  = In_Valid & In_Ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      elastic_reg_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .up_valid(in_take), .up_data(In_Data), .adv(adv[k]),
        .v_q(v[k]), .d_q(d[k])
      );
    end else begin : g_rest
      elastic_reg_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .up_valid(v[k-1]), .up_data(d[k-1]), .adv(adv[k]),
        .v_q(v[k]), .d_q(d[k])
      );
    end
  end

  assign Out_Data  = d[DEPTH-1];
  assign Out_Valid = v[DEPTH-1];

  always_comb begin
    Occupancy = '0;
    for (int k = 0; k < DEPTH; k++) Occupancy = Occupancy + OCC_W'(v[k]);
  end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
module tb_elastic_reg_pipe;

  logic       Clk, Reset, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic [7:0] In_Data, Out_Data;
  logic [1:0] Occupancy;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // random-phase stimulus shared by the DEPTH=1 and DEPTH=5 instances
  logic       rnd_rst, rnd_on, r_flush, r_iv, r_or;
  logic [7:0] r_din;

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Occupancy(Occupancy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clk);
  endtask

  // Scoreboard checkers for other depths: in-order, no loss/dup, occupancy
  // equals beats in flight, ready whenever not full or downstream draining.
  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int         DP = (g == 0) ? 1 : 5;
    localparam logic [7:0] RV = (g == 0) ? 8'h00 : 8'hE7;
    logic                          r_ir, r_ov;
    logic [7:0]                    r_od;
    logic [$clog2(DP+1)-1:0]       r_occ;
    logic [7:0]                    q[$];

    elastic_reg_pipe #(.WIDTH(8), .DEPTH(DP), .RESET_VALUE(RV)) u_dut (
      .Clk(Clk), .Reset(rnd_rst), .Flush(r_flush),
      .In_Data(r_din), .In_Valid(r_iv), .In_Ready(r_ir),
      .Out_Data(r_od), .Out_Valid(r_ov), .Out_Ready(r_or),
      .Occupancy(r_occ)
    );

    always @(negedge Clk) begin
      if (rnd_rst) begin
        q.delete();
        if (rnd_on) begin
          chk($sformatf("d%0d_rst_ov", DP), 32'(r_ov), 32'(0));
          chk($sformatf("d%0d_rst_od", DP), 32'(r_od), 32'(RV));
          chk($sformatf("d%0d_rst_occ", DP), 32'(r_occ), 32'(0));
          chk($sformatf("d%0d_rst_ir", DP), 32'(r_ir), 32'(0));
        end
      end else if (rnd_on) begin
        chk($sformatf("d%0d_occ", DP), 32'(r_occ), 32'(q.size()));
        chk($sformatf("d%0d_ir", DP), 32'(r_ir), 32'(!r_flush && (q.size() < DP || r_or)));
        if (r_ov) begin
          chk($sformatf("d%0d_ov_nonempty", DP), 32'(q.size() > 0), 32'(1));
          if (q.size() > 0) chk($sformatf("d%0d_od", DP), 32'(r_od), 32'(q[0]));
        end
        if (r_ov && r_or && q.size() > 0) void'(q.pop_front());
        if (r_flush) q.delete();
        else if (r_iv && r_ir) q.push_back(r_din);
      end
    end
  end

  logic [7:0] exp3 [3];

  initial begin
    Clk = 0; Reset = 1; Flush = 0; In_Valid = 0; In_Data = 8'h00; Out_Ready = 0;
    rnd_rst = 1; rnd_on = 0; r_flush = 0; r_iv = 0; r_or = 0; r_din = 8'h00;
    exp3[0] = 8'h22; exp3[1] = 8'h33; exp3[2] = 8'h44;

    // ---- reset state
    #2;
    chk("rst_ov", 32'(Out_Valid), 32'(0));
    chk("rst_od", 32'(Out_Data), 32'(0));
    chk("rst_occ", 32'(Occupancy), 32'(0));
    chk("rst_ir", 32'(In_Ready), 32'(0));

    // ---- 1: reset mid-stream with 3 beats held
    nxt(); Reset = 0;
    nxt(); In_Valid = 1; In_Data = 8'hC1;
    at_neg(); chk("t1_ir_first", 32'(In_Ready), 32'(1));
    nxt(); In_Data = 8'hC2;
    nxt(); In_Data = 8'hC3;
    nxt(); In_Valid = 0;
    at_neg();
    chk("t1_full_occ", 32'(Occupancy), 32'(3));
    chk("t1_full_ov", 32'(Out_Valid), 32'(1));
    chk("t1_full_od", 32'(Out_Data), 32'(8'hC1));
    chk("t1_full_ir", 32'(In_Ready), 32'(0));
    #1 Reset = 1;
    #1;
    chk("t1_async_ov", 32'(Out_Valid), 32'(0));
    chk("t1_async_occ", 32'(Occupancy), 32'(0));
    chk("t1_async_od", 32'(Out_Data), 32'(0));
    chk("t1_async_ir", 32'(In_Ready), 32'(0));
    nxt(); Reset = 0; Out_Ready = 1; In_Valid = 1; In_Data = 8'hA5;
    at_neg(); chk("t1_a5_ir", 32'(In_Ready), 32'(1));
    nxt(); In_Valid = 0;
    at_neg(); chk("t1_lat1_ov", 32'(Out_Valid), 32'(0));
    nxt(); at_neg(); chk("t1_lat2_ov", 32'(Out_Valid), 32'(0));
    nxt(); at_neg();
    chk("t1_lat3_ov", 32'(Out_Valid), 32'(1));
    chk("t1_lat3_od", 32'(Out_Data), 32'(8'hA5));
    nxt(); at_neg();
    chk("t1_drain_ov", 32'(Out_Valid), 32'(0));
    chk("t1_drain_occ", 32'(Occupancy), 32'(0));

    // ---- 2: back-to-back streaming, Out_Ready=1
    nxt();
    for (int c = 0; c < 19; c++) begin
      if (c < 16) begin In_Valid = 1; In_Data = 8'(c + 1); end
      else In_Valid = 0;
      at_neg();
      if (c < 16) chk("t2_ir", 32'(In_Ready), 32'(1));
      if (c >= 3) begin
        chk("t2_ov", 32'(Out_Valid), 32'(1));
        chk("t2_od", 32'(Out_Data), 32'(c - 2));
      end else chk("t2_ov_early", 32'(Out_Valid), 32'(0));
      nxt();
    end
    In_Valid = 0;
    at_neg(); chk("t2_empty_occ", 32'(Occupancy), 32'(0));

    // ---- 3: back-pressure
    nxt(); Out_Ready = 0; In_Valid = 1; In_Data = 8'h11;
    at_neg(); chk("t3_ir_11", 32'(In_Ready), 32'(1));
    nxt(); In_Data = 8'h22;
    nxt(); In_Data = 8'h33;
    at_neg(); chk("t3_ir_33", 32'(In_Ready), 32'(1));
    nxt(); In_Data = 8'h44;
    at_neg();
    chk("t3_ir_44", 32'(In_Ready), 32'(0));
    chk("t3_occ", 32'(Occupancy), 32'(3));
    chk("t3_ov", 32'(Out_Valid), 32'(1));
    chk("t3_od", 32'(Out_Data), 32'(8'h11));
    nxt(); at_neg();
    chk("t3_od_stable", 32'(Out_Data), 32'(8'h11));
    chk("t3_ir_still0", 32'(In_Ready), 32'(0));
    #1 Out_Ready = 1;
    #1 chk("t3_ir_passthru", 32'(In_Ready), 32'(1));
    nxt(); In_Valid = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t3_drain_ov", 32'(Out_Valid), 32'(1));
      chk("t3_drain_od", 32'(Out_Data), 32'(exp3[i]));
      nxt();
    end
    at_neg();
    chk("t3_end_ov", 32'(Out_Valid), 32'(0));
    chk("t3_end_occ", 32'(Occupancy), 32'(0));

    // ---- 4: bubble collapse while output stalled
    nxt(); Out_Ready = 0; In_Valid = 1; In_Data = 8'h5A;
    nxt(); In_Valid = 0;
    nxt();
    nxt(); In_Valid = 1; In_Data = 8'h6B;
    at_neg(); chk("t4_ir_6b", 32'(In_Ready), 32'(1));
    nxt(); In_Valid = 0;
    at_neg();
    chk("t4_occ", 32'(Occupancy), 32'(2));
    chk("t4_od", 32'(Out_Data), 32'(8'h5A));
    nxt(); at_neg();
    chk("t4_occ_hold", 32'(Occupancy), 32'(2));
    #1 Out_Ready = 1;
    nxt(); at_neg();
    chk("t4_adj_ov", 32'(Out_Valid), 32'(1));
    chk("t4_adj_od", 32'(Out_Data), 32'(8'h6B));
    nxt(); at_neg();
    chk("t4_end_ov", 32'(Out_Valid), 32'(0));
    chk("t4_end_occ", 32'(Occupancy), 32'(0));

    // ---- 5: flush with pending input
    nxt(); Out_Ready = 0; In_Valid = 1; In_Data = 8'h81;
    nxt(); In_Data = 8'h82;
    nxt(); In_Data = 8'h83;
    nxt(); Flush = 1; In_Data = 8'h77;
    at_neg();
    chk("t5_ir", 32'(In_Ready), 32'(0));
    chk("t5_occ_pre", 32'(Occupancy), 32'(3));
    nxt(); Flush = 0; In_Valid = 0; Out_Ready = 1;
    at_neg();
    chk("t5_occ", 32'(Occupancy), 32'(0));
    chk("t5_ov", 32'(Out_Valid), 32'(0));
    chk("t5_od", 32'(Out_Data), 32'(0));
    for (int i = 0; i < 5; i++) begin
      nxt(); at_neg();
      chk("t5_no77_ov", 32'(Out_Valid), 32'(0));
    end

    // ---- 6: random traffic on DEPTH=1 and DEPTH=5 with scoreboards
    nxt(); rnd_on = 1;
    nxt(); rnd_rst = 0;
    for (int i = 0; i < 3000; i++) begin
      r_iv    = ($urandom_range(0, 9) < 7);
      r_or    = ($urandom_range(0, 9) < 6);
      r_din   = 8'($urandom);
      r_flush = ($urandom_range(0, 63) == 0);
      nxt();
    end
    r_iv = 0; r_or = 1; r_flush = 0;
    repeat (8) nxt();
    at_neg();
    rnd_on = 0;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
